// File: rtl/lfsr_byte_collector.sv
// lfsr_byte_collector: packs strobed LFSR bits MSB-first into words, buffers them in a FIFO, flags stuck runs
module lfsr_byte_collector #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int RUN_LIMIT = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     bit_in,
   input  logic                     bit_en,
   input  logic                     clear,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     stuck
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(RUN_LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
   localparam logic [RW-1:0] RL   = RW'(RUN_LIMIT);

   logic [WIDTH-2:0] sr;
   logic [CW-1:0]    bitcnt;
   logic [AW-1:0]    wptr, rptr;
   logic [RW-1:0]    runlen, run_nx;
   logic             prev;
   logic [WIDTH-1:0] word;
   logic             push, pop, wr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign word      = {sr, bit_in};
   assign out_valid = level != '0;
   assign pop       = out_valid && out_ready && !clear;
   assign push      = bit_en && bitcnt == LAST && !clear;
   assign wr        = push && (level != FULL || pop);
   assign out_data  = out_valid ? mem[rptr] : '0;

   // next run length: restart at 1 on first sample or a change, else count up and saturate
   always_comb begin
      run_nx = RW'(1);
      if (runlen != '0 && bit_in == prev)
         run_nx = runlen == RL ? runlen : runlen + RW'(1);
   end

   // FIFO storage; unread entries are masked on out_data so no reset is needed
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= word;
   end

   // packing, FIFO pointers/level, run counter and sticky flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr       <= '0;
         bitcnt   <= '0;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         runlen   <= '0;
         prev     <= 1'b0;
         overflow <= 1'b0;
         stuck    <= 1'b0;
      end else if (clear) begin
         sr       <= '0;
         bitcnt   <= '0;
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         runlen   <= '0;
         prev     <= 1'b0;
         overflow <= 1'b0;
         stuck    <= 1'b0;
      end else begin
         if (bit_en) begin
            sr     <= word[WIDTH-2:0];
            bitcnt <= bitcnt == LAST ? '0 : bitcnt + CW'(1);
            prev   <= bit_in;
            runlen <= run_nx;
            if (run_nx == RL) stuck <= 1'b1;
         end
         if (wr) wptr <= wptr + AW'(1);
         if (pop) rptr <= rptr + AW'(1);
         level <= (wr && !pop) ? level + (AW + 1)'(1) :
                  (pop && !wr) ? level - (AW + 1)'(1) : level;
         if (push && !wr) overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_lfsr_byte_collector.sv
// tb_lfsr_byte_collector: directed vectors with hand-computed expectations
module tb_lfsr_byte_collector;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_en = 1'b0;
   logic       clear = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic       out_valid;
   logic [2:0] level;
   logic       overflow;
   logic       stuck;
   int         vectors = 0;
   int         errs = 0;

   lfsr_byte_collector #(.WIDTH(8), .DEPTH(4), .RUN_LIMIT(16)) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_en(bit_en), .clear(clear),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overflow(overflow), .stuck(stuck)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bit_in = b;
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   initial begin
      #12 rst = 1'b1;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_stuck", stuck, 0);

      // 1: B2 packing and latency
      send_bit(1); send_bit(0); send_bit(1); send_bit(1);
      send_bit(0); send_bit(0); send_bit(1);
      chk("t1_valid_7", out_valid, 0);
      send_bit(0);
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 8'hB2);
      chk("t1_level", level, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("t1_pop_level", level, 0);

      // 2: overflow drops the fifth word
      for (int k = 1; k <= 4; k++) send_word(8'(k));
      chk("t2_level4", level, 4);
      chk("t2_ovf0", overflow, 0);
      send_word(8'h05);
      chk("t2_level_full", level, 4);
      chk("t2_ovf1", overflow, 1);
      chk("t2_head_stable", out_data, 8'h01);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("t2_drain", out_data, k);
         tick();
      end
      out_ready = 1'b0;
      chk("t2_empty_valid", out_valid, 0);
      chk("t2_empty_level", level, 0);
      chk("t2_ovf_sticky", overflow, 1);
      do_clear();
      chk("t2_clr_ovf", overflow, 0);

      // 3: push and pop together at full
      send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
      chk("t3_level4", level, 4);
      send_bit(0); send_bit(1); send_bit(0); send_bit(1);
      send_bit(0); send_bit(1); send_bit(0);
      chk("t3_head_before", out_data, 8'h11);
      out_ready = 1'b1;
      send_bit(1);
      out_ready = 1'b0;
      chk("t3_level", level, 4);
      chk("t3_ovf", overflow, 0);
      out_ready = 1'b1;
      chk("t3_d22", out_data, 8'h22); tick();
      chk("t3_d33", out_data, 8'h33); tick();
      chk("t3_d44", out_data, 8'h44); tick();
      chk("t3_d55", out_data, 8'h55); tick();
      out_ready = 1'b0;
      chk("t3_empty", level, 0);
      do_clear();

      // 4: stuck detection
      for (int k = 0; k < 15; k++) send_bit(1);
      chk("t4_stuck15", stuck, 0);
      send_bit(1);
      chk("t4_stuck16", stuck, 1);
      chk("t4_level", level, 2);
      chk("t4_data", out_data, 8'hFF);
      send_bit(0);
      chk("t4_sticky", stuck, 1);
      do_clear();
      chk("t4_clr_stuck", stuck, 0);
      chk("t4_clr_level", level, 0);

      // 5: gaps between strobes, bit_in wiggling while idle
      for (int i = 7; i >= 0; i--) begin
         logic [7:0] w;
         w = 8'h5A;
         send_bit(w[i]);
         bit_in = ~w[i];
         tick();
         tick();
      end
      chk("t5_data", out_data, 8'h5A);
      chk("t5_level", level, 1);
      do_clear();

      // 6a: async reset mid-word
      for (int k = 0; k < 5; k++) send_bit(1);
      rst = 1'b0;
      #2;
      chk("t6_rst_level", level, 0);
      chk("t6_rst_valid", out_valid, 0);
      #2 rst = 1'b1;
      tick();
      send_word(8'hC3);
      chk("t6_rst_data", out_data, 8'hC3);
      chk("t6_rst_lvl1", level, 1);
      do_clear();

      // 6b: clear mid-word
      for (int k = 0; k < 5; k++) send_bit(1);
      do_clear();
      send_word(8'hC3);
      chk("t6_clr_data", out_data, 8'hC3);
      chk("t6_clr_lvl1", level, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
